// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub
//
// 16-bit adder/subtractor that works one nibble per clock through a single
// 4-bit carry-lookahead slice. A registered carry links the nibbles, from
// least significant to most significant. Subtraction is a + ~b + 1, so for
// a subtract, cout = 1 means no borrow.
//
// Handshake: start is sampled only in IDLE. On an accepting edge, a, b and
// sub are latched, and busy rises for exactly 5 cycles. Four clocks after
// the accept, done pulses for one cycle, and result and the flags are valid.
// They stay valid in IDLE until the next accepted start clears them. A start
// seen while busy is dropped and is not queued.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      operation request (sampled in IDLE)
//   sub        0 = add, 1 = subtract (latched with start)
//   a, b       16-bit operands (latched with start)
//   busy       high in RUN and DONE
//   done       one-cycle completion pulse
//   result     sum or difference
//   cout       carry out of bit 15
//   overflow   two's-complement signed overflow
//   zero       result == 0
//   dbg_state  current FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
module nibble_serial_addsub (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        sub,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic        cout,
   output logic        overflow,
   output logic        zero,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state, state_next;
   logic [1:0]  idx;
   logic        carry;
   logic [15:0] opa, opb;

   logic [3:0]  na, nb, g, p, sum;
   logic [4:0]  c;
   logic [15:0] res_next;

   // Slice for the nibble selected by idx.
   always_comb begin
      na   = opa[{idx, 2'b00} +: 4];
      nb   = opb[{idx, 2'b00} +: 4];
      g    = na & nb;
      p    = na ^ nb;
      c[0] = carry;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
      sum  = p ^ c[3:0];
      res_next = result;
      res_next[{idx, 2'b00} +: 4] = sum;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (idx == 2'd3) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opa      <= '0;
         opb      <= '0;
         carry    <= 1'b0;
         idx      <= 2'd0;
         result   <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  opa      <= a;
                  opb      <= sub ? ~b : b;
                  carry    <= sub;  // the +1 of a two's-complement subtract
                  idx      <= 2'd0;
                  result   <= '0;
                  cout     <= 1'b0;
                  overflow <= 1'b0;
                  zero     <= 1'b0;
               end
            end
            RUN: begin
               result <= res_next;
               carry  <= c[4];
               idx    <= idx + 2'd1;
               if (idx == 2'd3) begin
                  cout <= c[4];
                  // Carry into bit 15, recovered from the sum bit, XOR carry out.
                  overflow <= (opa[15] ^ opb[15] ^ sum[3]) ^ c[4];
                  zero     <= (res_next == 16'h0000);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign dbg_state = state;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
module tb_nibble_serial_addsub;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        sub = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        busy, done, cout, overflow, zero;
   logic [15:0] result;
   logic [1:0]  dbg_state;

   int checks = 0;
   int failures = 0;
   logic [15:0] exp_q[$];

   nibble_serial_addsub dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .cout(cout),
      .overflow(overflow), .zero(zero), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic [15:0] res;
      logic        co;
      logic        ov;
      logic        z;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation, scramble the inputs once it is accepted, and
   // wait (bounded) for done. Checks latency, busy duration, and the results.
   task automatic run_op(input string name, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tsub, input logic [15:0] er, input logic eco,
                         input logic eov, input logic ez);
      int lat;
      int busy_cnt;
      a = ta; b = tb; sub = tsub; start = 1'b1;
      step();
      start = 1'b0;
      chk({name, "_accept_busy"}, busy, 1);
      chk({name, "_accept_clear"}, {result, cout, overflow, zero}, 0);
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom_range(0, 1));
      lat = 0;
      busy_cnt = 1;
      while (!done && lat < 10) begin
         step();
         lat++;
         if (busy) busy_cnt++;
      end
      chk({name, "_latency"}, lat, 4);
      chk({name, "_busy_cycles"}, busy_cnt, 5);
      chk({name, "_result"}, result, er);
      chk({name, "_flags"}, {cout, overflow, zero}, {eco, eov, ez});
      step();
      chk({name, "_idle"}, {busy, done}, 0);
      step();
      chk({name, "_hold"}, {result, cout, overflow, zero}, {er, eco, eov, ez});
   endtask

   initial begin
      int dcnt;
      int dcyc[$];
      logic [15:0] r;

      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
      vecs[7] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_outputs", {busy, done, result, cout, overflow, zero}, 0);
      chk("reset_state", dbg_state, 0);

      for (int i = 0; i < 8; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                vecs[i].res, vecs[i].co, vecs[i].ov, vecs[i].z);
      end

      // A start during RUN is ignored, and input changes have no effect.
      a = 16'h000F; b = 16'h0001; sub = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      dcnt = 0;
      r = '0;
      for (int i = 1; i <= 12; i++) begin
         step();
         if (i == 1) begin start = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b1; end
         if (i == 2) start = 1'b0;
         if (i == 3) begin a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; end
         if (done) begin dcnt++; r = result; end
      end
      chk("ignore_done_count", dcnt, 1);
      chk("ignore_result", r, 16'h0010);
      chk("ignore_flags", {cout, overflow, zero}, 0);
      chk("ignore_no_requeue", busy, 0);

      // Reset mid-operation abandons it, and reset wins over start.
      a = 16'h00FF; b = 16'h0001; sub = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      chk("pre_reset_busy", busy, 1);
      rst = 1'b1;
      start = 1'b1;
      #1;
      chk("async_reset_outputs", {busy, done, result, cout, overflow, zero}, 0);
      step();
      chk("reset_beats_start", {busy, dbg_state}, 0);
      rst = 1'b0;
      start = 1'b0;
      dcnt = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (done) dcnt++;
      end
      chk("reset_no_done", dcnt, 0);
      run_op("post_reset", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

      // Start held high: back-to-back accepts, 6 clocks apart.
      a = 16'h0100; b = 16'h0100; sub = 1'b0; start = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (busy && dbg_state == 2'd1 && result == 16'h0000 && !done) begin
            if (exp_q.size() == 0 || dcyc.size() >= exp_q.size()) exp_q.push_back(16'h0200);
         end
         if (done) begin
            dcyc.push_back(i);
            if (exp_q.size() == 0) chk("held_unexpected_done", 1, 0);
            else chk("held_result", result, exp_q.pop_front());
         end
      end
      start = 1'b0;
      chk("held_done_count", dcyc.size(), 3);
      if (dcyc.size() >= 3) begin
         chk("held_first_done", dcyc[0], 5);
         chk("held_spacing_1", dcyc[1] - dcyc[0], 6);
         chk("held_spacing_2", dcyc[2] - dcyc[1], 6);
      end
      for (int i = 0; i < 10 && busy; i++) step();
      chk("held_back_to_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
